// File: rtl/snake_game_ctrl.sv
// Snake game control FSM: menu/play/over sequencing, per-frame body shift and
// head step strobes, direction filtering, and length/score bookkeeping.
module snake_game_ctrl #(
  parameter int unsigned INIT_LEN = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic [3:0] dir_btn,
  input  logic       frame_tick,
  input  logic       hit_wall,
  input  logic       hit_self,
  input  logic       ate_apple,
  output logic       inmenu,
  output logic       ingame,
  output logic       gameover,
  output logic [4:0] direction,
  output logic       init_snake,
  output logic       shift_en,
  output logic [6:0] shift_idx,
  output logic       head_step,
  output logic       grow,
  output logic [6:0] length,
  output logic [7:0] score
);

  typedef enum logic [2:0] {
    S_MENU, S_INIT, S_WAIT, S_SHIFT, S_HEAD, S_CHECK, S_OVER
  } state_t;

  localparam logic [4:0] DIR_UP    = 5'b00001;
  localparam logic [4:0] DIR_DOWN  = 5'b00010;
  localparam logic [4:0] DIR_LEFT  = 5'b00100;
  localparam logic [4:0] DIR_RIGHT = 5'b01000;
  localparam logic [4:0] DIR_STOP  = 5'b10000;
  localparam logic [6:0] LEN_INIT  = 7'(INIT_LEN);

  state_t     state;
  logic       go_q;
  logic       go_rise;
  logic [6:0] idx;
  logic [4:0] pend_dir;
  logic [4:0] btn_dir;
  logic [4:0] rev_dir;
  logic       btn_ok;

  assign go_rise   = go & ~go_q;
  assign shift_idx = idx;
  assign inmenu    = (state == S_MENU);
  assign gameover  = (state == S_OVER);
  assign ingame    = !inmenu && !gameover;

  // Reversal is judged against the committed direction, not the pending one,
  // so two presses in one frame can never produce a 180-degree turn.
  always_comb begin
    btn_dir = {1'b0, dir_btn};
    rev_dir = '0;
    case (direction)
      DIR_UP:    rev_dir = DIR_DOWN;
      DIR_DOWN:  rev_dir = DIR_UP;
      DIR_LEFT:  rev_dir = DIR_RIGHT;
      DIR_RIGHT: rev_dir = DIR_LEFT;
      default:   rev_dir = '0;
    endcase
    btn_ok = $onehot(dir_btn) && (btn_dir != rev_dir);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_MENU;
      go_q       <= 1'b0;
      idx        <= '0;
      pend_dir   <= DIR_STOP;
      direction  <= DIR_STOP;
      length     <= LEN_INIT;
      score      <= '0;
      init_snake <= 1'b0;
      shift_en   <= 1'b0;
      head_step  <= 1'b0;
      grow       <= 1'b0;
    end else begin
      go_q       <= go;
      init_snake <= 1'b0;
      shift_en   <= 1'b0;
      head_step  <= 1'b0;
      grow       <= 1'b0;

      if ((state inside {S_WAIT, S_SHIFT, S_HEAD, S_CHECK}) && btn_ok)
        pend_dir <= btn_dir;

      case (state)
        S_MENU: begin
          if (go_rise) begin
            state      <= S_INIT;
            init_snake <= 1'b1;
          end
        end
        S_INIT: begin
          length    <= LEN_INIT;
          score     <= '0;
          direction <= DIR_RIGHT;
          pend_dir  <= DIR_RIGHT;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (frame_tick) begin
            state    <= S_SHIFT;
            idx      <= length - 7'd1;
            shift_en <= 1'b1;
          end
        end
        S_SHIFT: begin
          idx <= idx - 7'd1;
          if (idx == 7'd1) begin
            state     <= S_HEAD;
            head_step <= 1'b1;
            direction <= pend_dir;
          end else begin
            shift_en <= 1'b1;
          end
        end
        S_HEAD: state <= S_CHECK;
        S_CHECK: begin
          if (hit_wall || hit_self) begin
            state <= S_OVER;
          end else begin
            state <= S_WAIT;
            if (ate_apple) begin
              grow <= 1'b1;
              if (length != 7'd127) length <= length + 7'd1;
              if (score != 8'd255)  score  <= score + 8'd1;
            end
          end
        end
        S_OVER: begin
          if (go_rise) state <= S_MENU;
        end
        default: state <= S_MENU;
      endcase
    end
  end

endmodule

// File: doc/snake_game_ctrl.md
SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 SHALL have parameter INIT_LEN, default 3, meaning snake length loaded on game start (range 2..127).
REQ-002 SHALL have port clk  in  1  system clock (CLOCK_50 domain); all state changes on posedge clk.
REQ-003 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port go  in  1  start/restart request, active-high level; top level inverts KEY.
REQ-005 SHALL have port dir_btn  in  4  direction request, [0]=up [1]=down [2]=left [3]=right, active-high.
REQ-006 SHALL have port frame_tick  in  1  one-cycle pulse from the frame updater.
REQ-007 SHALL have port hit_wall  in  1  datapath flag: head on border, sampled only in CHECK.
REQ-008 SHALL have port hit_self  in  1  datapath flag: head on body, sampled only in CHECK.
REQ-009 SHALL have port ate_apple  in  1  datapath flag: head on apple, sampled only in CHECK.
REQ-010 SHALL have port inmenu / ingame / gameover  out  1 each  one-hot game status.
REQ-011 SHALL have port direction  out  5  one-hot: 00001 up, 00010 down, 00100 left, 01000 right, 10000 stopped.
REQ-012 SHALL have port init_snake  out  1  one-cycle pulse: datapath loads start body of length INIT_LEN.
REQ-013 SHALL have port shift_en  out  1  body-shift strobe: datapath copies segment shift_idx-1 into shift_idx.
REQ-014 SHALL have port shift_idx  out  7  segment index for shift_en.
REQ-015 SHALL have port head_step  out  1  one-cycle pulse: datapath moves head one cell per direction.
REQ-016 SHALL have port grow  out  1  one-cycle pulse: apple eaten, datapath respawns apple.
REQ-017 SHALL have port length  out  7  current snake length; score  out  8  apples eaten.

Function
REQ-018 SHALL implement states MENU, INIT, WAIT, SHIFT, HEAD, CHECK, OVER; inmenu=1 only in MENU, gameover=1 only in OVER, ingame=1 in INIT/WAIT/SHIFT/HEAD/CHECK.
REQ-019 SHALL detect go rising edge via registered go_q (go & ~go_q); level-held go never retriggers.
REQ-020 MENU: on go edge -> INIT; otherwise stay.
REQ-021 INIT: one cycle; init_snake=1; length<=INIT_LEN, score<=0, direction and pending direction<=right; -> WAIT.
REQ-022 WAIT: on frame_tick -> SHIFT with idx<=length-1; frame_tick in any other state is dropped, not queued.
REQ-023 SHIFT: shift_en=1, shift_idx=idx each cycle; idx decrements; cycle with idx==1 is last -> HEAD; exactly length-1 strobes, descending.
REQ-024 On the edge entering HEAD, direction<=pending direction; HEAD lasts one cycle with head_step=1 -> CHECK.
REQ-025 CHECK: one cycle; hit_wall|hit_self -> OVER (collision wins over ate_apple); else ate_apple -> grow=1, length+1 saturating at 127, score+1 saturating at 255; -> WAIT.
REQ-026 OVER: length, score, direction frozen; on go edge -> MENU.
REQ-027 Pending direction SHALL update only in WAIT/SHIFT/HEAD/CHECK and only when dir_btn is exactly one-hot and not opposite to current direction output; zero or multi-bit dir_btn ignored.
REQ-028 Reversal check SHALL use committed direction, so two presses within one frame cannot produce a 180-degree turn.
REQ-029 shift_en, head_step, grow, init_snake SHALL be registered outputs, never asserted simultaneously.

Reset
REQ-030 resetn=0 SHALL immediately force MENU, direction=10000, length=INIT_LEN, score=0, go_q=0, idx=0, all strobes 0, inmenu=1, ingame=0, gameover=0.
REQ-031 Reset mid-SHIFT/HEAD/CHECK SHALL abort the sequence with no further strobes; first post-reset go edge required to play.

Verification
REQ-032 Reset, go 0->1 -> one cycle init_snake=1, then WAIT with direction=01000, length=3, score=0.
REQ-033 In WAIT pulse frame_tick -> shift_en on 2 cycles with shift_idx 2,1, then head_step 1 cycle, CHECK, back to WAIT: 4 cycles total.
REQ-034 Moving right, press left then up in one frame -> direction becomes 00001 at HEAD; press left alone -> ignored, stays 01000.
REQ-035 CHECK with ate_apple=1 and hit_self=0 -> grow pulse, length 3->4, score 0->1; next frame gives 3 shift strobes (3,2,1).
REQ-036 CHECK with ate_apple=1 and hit_wall=1 -> OVER, gameover=1, no grow, score unchanged; go edge -> MENU.
REQ-037 Assert resetn=0 during SHIFT with idx=5 -> shift_en drops same cycle asynchronously, inmenu=1, length=3.
